adc_framer: RTL and testbench
=============================

Name: adc_framer

Overview:
- Parametrised successor to the single-channel ADC packer feeding the ADC-to-Ethernet FIFO.
- Accepts CH parallel ADC channels and applies programmable decimation.
- Packs samples into wide FIFO words and wraps them in fixed-length frames, each with a header word.
- Supports continuous or armed/triggered single-frame capture, and reports overflow against the FIFO Almost_Full signal.
- Sits in the clk50 domain, between the ADC pins and the write side of the dual-clock FIFO.

Parameters:
- SW, 10: bits per sample.
- CH, 1: channels sampled per ivalid cycle.
- PACK, 4: samples per output word. OW = SW*PACK, with OW >= 32. PACK % CH == 0 and PACK/CH >= 2; violating either is an elaboration error.
- FRAME_WORDS, 256: data words per frame, excluding the header.
- DEC_W, 8: width of the decimation control.

Ports:
- clk50  in  1  sample clock.
- reset  in  1  synchronous, active-high.
- idata  in  CH*SW  channel c occupies bits [c*SW +: SW].
- ivalid  in  1  idata valid this cycle.
- cfg_dec  in  DEC_W  keep 1 of every cfg_dec+1 valid vectors.
- cfg_mode  in  1  0 = continuous, 1 = triggered single frame.
- arm  in  1  pulse; arms a triggered capture.
- trig  in  1  level; starts the armed capture.
- afull  in  1  FIFO Almost_Full.
- odata  out  OW  word to FIFO.
- wren  out  1  FIFO write strobe.
- busy  out  1  state != IDLE.
- drop_cnt  out  16  words lost to afull, saturating.

Behaviour:
- Clock and reset: one clock, clk50. reset is synchronous and active-high.
- Reset values: state = IDLE; wren = 0; odata = 0; busy = 0; drop_cnt = 0; decimation counter = 0; lane index = 0; word count = 0; sequence = 0; ovf flag = 0.
- FSM states: IDLE, ARMED, RUN.
- IDLE -> RUN when cfg_mode = 0 (next cycle).
- IDLE -> ARMED on arm when cfg_mode = 1.
- ARMED -> RUN on the first cycle with trig = 1.
- RUN -> IDLE after FRAME_WORDS data words have been emitted or dropped, in triggered mode.
- In continuous mode, RUN starts the next frame immediately.
- cfg_mode and cfg_dec are sampled only in IDLE and at frame start. Mid-frame changes are ignored.
- Decimation: in RUN, each ivalid cycle is "accepted" iff dec counter = 0. On every ivalid cycle the counter reloads to cfg_dec on accept, else decrements. The counter is cleared on entry to RUN. cfg_dec = 0 accepts every valid vector.
- Packing: each accepted vector writes CH samples into lanes [lane .. lane+CH-1], channel 0 in the lowest lane, lane 0 at odata LSBs. The word completes when the lane index wraps at PACK.
- Word write: wren pulses one cycle after the completing accept, with odata registered (latency 1).
- Header word: written (wren = 1) one cycle after the first accepted vector of each frame. PACK/CH >= 2 guarantees it never collides with a data write.
- Header layout: [31] = ovf flag of the previous frame; [30:24] = 7'h5A; [23:16] = CH; [15:0] = frame sequence; bits above 31 are zero.
- Sequence increments (mod 2^16) after each header write.
- Backpressure: if afull = 1 in the cycle a header or data write would occur, the write is suppressed (wren = 0) and drop_cnt increments, saturating at 16'hFFFF.
  - The ovf flag is set for the frame in which the drop occurs.
  - A dropped data word still counts toward FRAME_WORDS, so frame length in samples stays fixed.
  - A dropped header still advances the sequence.
- ovf flag: cleared when the next header is written, after it has been reported in bit 31.
- reset mid-frame: partial word discarded, no write, all state returns to IDLE. drop_cnt clears only on reset.
- ivalid = 0 cycles: no effect on any counters.

Decomposition:
- Package adc_framer_pkg: state enum (IDLE, ARMED, RUN), HDR_MARK = 7'h5A, header field offsets, and a function building the header from ovf, CH and seq.
- Sub-module adc_lane_packer: lane index, shift-in of CH samples, word-complete strobe.
- Top level adc_framer: FSM, decimation, framing, backpressure.

Test Plan:
- Defaults, cfg_mode = 0, cfg_dec = 0, ramp 0,1,2,... on every cycle, FRAME_WORDS = 4 -> header 32'h5A01_0000, then {3,2,1,0} packed (odata = 40'h00C0_2004_00 pattern, i.e. lanes 0..3 = 0..3), 4 data words, next header seq = 1.
- cfg_dec = 2, continuous ramp -> data word lanes = 0,3,6,9.
- CH = 2, PACK = 4: ch0 = 10'h001 and ch1 = 10'h002 on every vector -> lanes = 1,2,1,2, one data word every 2 accepts.
- cfg_mode = 1: trig asserted before arm -> no writes. Then arm, trig -> exactly 1 header + FRAME_WORDS writes, busy falls, state IDLE.
- afull held high across 2 data-word slots -> wren suppressed, drop_cnt = 2, next frame's header bit 31 = 1, and the header after that has bit 31 = 0.
- reset asserted at lane index 2 mid-frame -> no wren that cycle or after; on restart the header seq = 0 and drop_cnt = 0.

Source files
------------

// File: rtl/adc_framer_pkg.sv
// Shared types and header construction for the ADC framer.
// The header occupies the low 32 bits of an output word; any wider bits stay zero.
package adc_framer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  localparam logic [6:0] HDR_MARK     = 7'h5A;
  localparam int         HDR_OVF_BIT  = 31;
  localparam int         HDR_MARK_LSB = 24;
  localparam int         HDR_CH_LSB   = 16;
  localparam int         HDR_SEQ_LSB  = 0;

  function automatic logic [31:0] build_header(input logic        ovf,
                                               input logic [7:0]  ch,
                                               input logic [15:0] seq);
    logic [31:0] h;
    h                      = '0;
    h[HDR_OVF_BIT]         = ovf;
    h[HDR_MARK_LSB +: 7]   = HDR_MARK;
    h[HDR_CH_LSB +: 8]     = ch;
    h[HDR_SEQ_LSB +: 16]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/adc_framer_if.sv
// Sample input and FIFO write-side bundle of the ADC framer.
// master is the ADC/FIFO environment, slave is the framer.
interface adc_framer_if #(
  parameter int SW   = 10,
  parameter int CH   = 1,
  parameter int PACK = 4
);
  localparam int OW = SW * PACK;

  logic [CH*SW-1:0] idata;
  logic             ivalid;
  logic             afull;
  logic [OW-1:0]    odata;
  logic             wren;

  modport master (output idata, ivalid, afull, input odata, wren);
  modport slave  (input idata, ivalid, afull, output odata, wren);
endinterface

// File: rtl/adc_lane_packer.sv
// Collects CH-sample vectors into PACK-lane words, lane 0 at the LSBs.
// word_next is the word including the vector being accepted this cycle.
module adc_lane_packer #(
  parameter int SW   = 10,
  parameter int CH   = 1,
  parameter int PACK = 4
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               accept,
  input  logic [CH*SW-1:0]   samples,
  output logic [SW*PACK-1:0] word_next,
  output logic               word_done
);

  localparam int SLOTS  = PACK / CH;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int VW     = CH * SW;

  logic [SLOT_W-1:0] slot;
  logic [VW-1:0]     lanes [SLOTS];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk50) begin
    if (reset) begin
      slot <= '0;
    end else if (accept) begin
      slot <= (slot == SLOT_W'(SLOTS - 1)) ? '0 : slot + SLOT_W'(1);
    end
  end

  // NOTE: lane storage has no reset; every slot is rewritten before its word is emitted.
  always_ff @(posedge clk50) begin
    if (accept) lanes[slot] <= samples;
  end

  // NOTE: word_next gets a default first so no path through the loop can infer a latch.
  always_comb begin
    word_next = '0;
    for (int s = 0; s < SLOTS; s++) begin
      word_next[s*VW +: VW] = (accept && slot == SLOT_W'(s)) ? samples : lanes[s];
    end
  end

  assign word_done = accept && (slot == SLOT_W'(SLOTS - 1));

endmodule

// File: rtl/adc_framer.sv
// Decimates CH-channel ADC vectors, packs them into FIFO words and frames them
// with a header word; continuous or armed/triggered single-frame capture.
module adc_framer
  import adc_framer_pkg::*;
#(
  parameter int SW          = 10,
  parameter int CH          = 1,
  parameter int PACK        = 4,
  parameter int FRAME_WORDS = 256,
  parameter int DEC_W       = 8
) (
  input  logic             clk50,
  input  logic             reset,
  adc_framer_if.slave      bus,
  input  logic [DEC_W-1:0] cfg_dec,
  input  logic             cfg_mode,
  input  logic             arm,
  input  logic             trig,
  output logic             busy,
  output logic [15:0]      drop_cnt
);

  localparam int OW   = SW * PACK;
  localparam int WC_W = $clog2(FRAME_WORDS + 1);

  generate
    if (OW < 32 || (PACK % CH) != 0 || (PACK / CH) < 2) begin : g_bad_params
      $error("adc_framer: illegal SW/CH/PACK combination");
    end
  endgenerate

  state_t           state;
  logic             mode_q;
  logic [DEC_W-1:0] dec_q;
  logic [DEC_W-1:0] dec_cnt;
  logic [WC_W-1:0]  word_cnt;
  logic [15:0]      seq;
  logic             ovf;
  logic             first_pend;

  logic             accept;
  logic             hdr_due;
  logic             write_due;
  logic             last_word;
  logic [OW-1:0]    word_next;
  logic             word_done;

  assign accept    = (state == RUN) && bus.ivalid && (dec_cnt == '0);
  assign hdr_due   = accept && first_pend;
  assign write_due = hdr_due || word_done;
  assign last_word = word_done && (word_cnt == WC_W'(FRAME_WORDS - 1));
  assign busy      = (state != IDLE);

  adc_lane_packer #(
    .SW   (SW),
    .CH   (CH),
    .PACK (PACK)
  ) u_packer (
    .clk50     (clk50),
    .reset     (reset),
    .accept    (accept),
    .samples   (bus.idata),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      dec_q      <= '0;
      dec_cnt    <= '0;
      word_cnt   <= '0;
      seq        <= '0;
      ovf        <= 1'b0;
      first_pend <= 1'b1;
      drop_cnt   <= '0;
      bus.wren   <= 1'b0;
      bus.odata  <= '0;
    end else begin
      bus.wren <= 1'b0;

      // afull is judged in the accept cycle so that wren stays a plain flop.
      if (write_due) begin
        if (bus.afull) begin
          ovf <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          bus.wren  <= 1'b1;
          bus.odata <= hdr_due ? OW'(build_header(ovf, 8'(CH), seq)) : word_next;
          if (hdr_due) ovf <= 1'b0;
        end
      end

      if (hdr_due) begin
        seq        <= seq + 16'd1;
        first_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          mode_q     <= cfg_mode;
          dec_q      <= cfg_dec;
          dec_cnt    <= '0;
          word_cnt   <= '0;
          first_pend <= 1'b1;
          if (!cfg_mode)  state <= RUN;
          else if (arm)   state <= ARMED;
        end
        ARMED: begin
          if (trig) begin
            state   <= RUN;
            dec_q   <= cfg_dec;
            dec_cnt <= '0;
          end
        end
        RUN: begin
          if (bus.ivalid) dec_cnt <= accept ? dec_q : dec_cnt - DEC_W'(1);
          if (word_done)  word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
          // A switch to triggered mode seen at a frame boundary ends continuous capture.
          if (last_word) begin
            first_pend <= 1'b1;
            if (mode_q || cfg_mode) state <= IDLE;
            else                    dec_q <= cfg_dec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_framer.sv
// Self-checking bench for adc_framer: directed table, corner sequences and
// randomized traffic against a sample-queue reference model.
module tb_adc_framer;

  localparam int SW    = 10;
  localparam int PACK  = 4;
  localparam int FW    = 4;
  localparam int DEC_W = 8;
  localparam int OW    = SW * PACK;

  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic             reset;
  logic [DEC_W-1:0] cfg_dec;
  logic             cfg_mode;
  logic             arm;
  logic             trig;
  logic             busy1, busy2;
  logic [15:0]      drop1, drop2;

  adc_framer_if #(.SW(SW), .CH(1), .PACK(PACK)) bus1 ();
  adc_framer_if #(.SW(SW), .CH(2), .PACK(PACK)) bus2 ();

  adc_framer #(.SW(SW), .CH(1), .PACK(PACK), .FRAME_WORDS(FW), .DEC_W(DEC_W)) u_dut1 (
    .clk50(clk50), .reset(reset), .bus(bus1), .cfg_dec(cfg_dec), .cfg_mode(cfg_mode),
    .arm(arm), .trig(trig), .busy(busy1), .drop_cnt(drop1)
  );

  adc_framer #(.SW(SW), .CH(2), .PACK(PACK), .FRAME_WORDS(FW), .DEC_W(DEC_W)) u_dut2 (
    .clk50(clk50), .reset(reset), .bus(bus2), .cfg_dec(cfg_dec), .cfg_mode(cfg_mode),
    .arm(arm), .trig(trig), .busy(busy2), .drop_cnt(drop2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model for the CH=1 instance: frames built from a queue of kept samples.
  bit            m_run, m_armed, m_mode, m_first, m_ovf, m_wren;
  int            m_dec, m_vidx, m_words, m_drop;
  logic [15:0]   m_seq;
  logic [OW-1:0] m_odata;
  int            m_samples[$];

  logic [OW-1:0] wr1[$];
  logic [OW-1:0] wr2[$];
  int            ramp_v;

  task automatic m_enter_run();
    m_run   = 1'b1;
    m_armed = 1'b0;
    m_vidx  = 0;
    m_first = 1'b1;
    m_words = 0;
    m_samples.delete();
  endtask

  task automatic m_emit(input logic [OW-1:0] val, input bit is_hdr);
    if (bus1.afull) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end else begin
      m_wren  = 1'b1;
      m_odata = val;
      if (is_hdr) m_ovf = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [OW-1:0] w;
    if (reset) begin
      m_run = 0; m_armed = 0; m_mode = 0; m_first = 1; m_ovf = 0; m_wren = 0;
      m_dec = 0; m_vidx = 0; m_words = 0; m_drop = 0; m_seq = 0; m_odata = '0;
      m_samples.delete();
      return;
    end
    m_wren = 1'b0;
    if (!m_run && !m_armed) begin
      m_mode = cfg_mode;
      m_dec  = int'(cfg_dec);
      if (!cfg_mode)  m_enter_run();
      else if (arm)   m_armed = 1'b1;
    end else if (m_armed) begin
      if (trig) begin
        m_dec = int'(cfg_dec);
        m_enter_run();
      end
    end else if (bus1.ivalid) begin
      if ((m_vidx % (m_dec + 1)) == 0) begin
        if (m_first) begin
          w = (m_ovf ? 40'h0080000000 : 40'h0) + 40'h005A000000 + 40'h0000010000 + OW'(m_seq);
          m_emit(w, 1'b1);
          m_seq++;
          m_first = 1'b0;
        end
        m_samples.push_back(int'(bus1.idata));
        if (m_samples.size() == PACK) begin
          w = '0;
          for (int i = 0; i < PACK; i++) w = w + (OW'(m_samples[i]) << (SW * i));
          m_samples.delete();
          m_emit(w, 1'b0);
          m_words++;
          if (m_words == FW) begin
            m_words = 0;
            m_first = 1'b1;
            if (m_mode || cfg_mode) m_run = 1'b0;
            else                    m_dec = int'(cfg_dec);
          end
        end
      end
      m_vidx++;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk50);
    @(negedge clk50);
    check("wren",     64'(bus1.wren),  64'(m_wren));
    check("odata",    64'(bus1.odata), 64'(m_odata));
    check("busy",     64'(busy1),      64'(m_run || m_armed));
    check("drop_cnt", 64'(drop1),      64'(m_drop));
    if (bus1.wren) wr1.push_back(bus1.odata);
    if (bus2.wren) wr2.push_back(bus2.odata);
  endtask

  task automatic drive(input bit iv, input logic [SW-1:0] d, input bit af);
    bus1.ivalid = iv;
    bus1.idata  = d;
    bus1.afull  = af;
    bus2.ivalid = iv;
    bus2.afull  = af;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arm   = 1'b0;
    trig  = 1'b0;
    drive(1'b0, '0, 1'b0);
    cyc();
    cyc();
    reset  = 1'b0;
    ramp_v = 0;
  endtask

  task automatic run_ramp(input int n, input bit af);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, SW'(ramp_v), af);
      ramp_v++;
      cyc();
    end
  endtask

  typedef struct {
    bit            ivalid;
    logic [SW-1:0] din;
    bit            exp_wren;
    logic [OW-1:0] exp_odata;
  } vec_t;

  vec_t tbl[19];

  initial begin
    cfg_dec     = '0;
    cfg_mode    = 1'b0;
    bus2.idata  = {10'h002, 10'h001};
    do_reset();
    check("reset_odata", 64'(bus1.odata), 64'h0);
    check("reset_busy",  64'(busy1),      64'h0);

    // Continuous ramp, no decimation: header, four words, next header seq 1.
    tbl[0]  = '{1'b0, 10'd0,   1'b0, 40'h0};
    tbl[1]  = '{1'b1, 10'd0,   1'b1, 40'h005A010000};
    tbl[2]  = '{1'b1, 10'd1,   1'b0, 40'h0};
    tbl[3]  = '{1'b1, 10'd2,   1'b0, 40'h0};
    tbl[4]  = '{1'b1, 10'd3,   1'b1, 40'h00C0200400};
    tbl[5]  = '{1'b1, 10'd4,   1'b0, 40'h0};
    tbl[6]  = '{1'b1, 10'd5,   1'b0, 40'h0};
    tbl[7]  = '{1'b0, 10'h3FF, 1'b0, 40'h0};
    tbl[8]  = '{1'b1, 10'd6,   1'b0, 40'h0};
    tbl[9]  = '{1'b1, 10'd7,   1'b1, 40'h01C0601404};
    tbl[10] = '{1'b1, 10'd8,   1'b0, 40'h0};
    tbl[11] = '{1'b1, 10'd9,   1'b0, 40'h0};
    tbl[12] = '{1'b1, 10'd10,  1'b0, 40'h0};
    tbl[13] = '{1'b1, 10'd11,  1'b1, 40'h02C0A02408};
    tbl[14] = '{1'b1, 10'd12,  1'b0, 40'h0};
    tbl[15] = '{1'b1, 10'd13,  1'b0, 40'h0};
    tbl[16] = '{1'b1, 10'd14,  1'b0, 40'h0};
    tbl[17] = '{1'b1, 10'd15,  1'b1, 40'h03C0E0340C};
    tbl[18] = '{1'b1, 10'd16,  1'b1, 40'h005A010001};
    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].ivalid, tbl[k].din, 1'b0);
      cyc();
      check($sformatf("tbl%0d_wren", k), 64'(bus1.wren), 64'(tbl[k].exp_wren));
      if (tbl[k].exp_wren) check($sformatf("tbl%0d_odata", k), 64'(bus1.odata), 64'(tbl[k].exp_odata));
    end

    // Decimation by 3: first data word holds samples 0,3,6,9.
    do_reset();
    cfg_dec = 8'd2;
    wr1.delete();
    drive(1'b0, '0, 1'b0);
    cyc();
    run_ramp(12, 1'b0);
    check("dec_writes", 64'(wr1.size()), 64'd2);
    if (wr1.size() >= 2) begin
      check("dec_hdr",  64'(wr1[0]), 64'h005A010000);
      check("dec_word", 64'(wr1[1]), 64'h0240600C00);
    end

    // Two channels: lanes 1,2,1,2 and one word per two accepts.
    cfg_dec = '0;
    do_reset();
    wr2.delete();
    drive(1'b0, '0, 1'b0);
    cyc();
    run_ramp(5, 1'b0);
    check("ch2_writes", 64'(wr2.size()), 64'd3);
    if (wr2.size() >= 3) begin
      check("ch2_hdr",   64'(wr2[0]), 64'h005A020000);
      check("ch2_word0", 64'(wr2[1]), 64'h0080100801);
      check("ch2_word1", 64'(wr2[2]), 64'h0080100801);
    end

    // Triggered capture: trig before arm does nothing; arm then trig gives one frame.
    cfg_mode = 1'b1;
    do_reset();
    wr1.delete();
    trig = 1'b1;
    run_ramp(5, 1'b0);
    check("trig_noarm_writes", 64'(wr1.size()), 64'd0);
    check("trig_noarm_busy",   64'(busy1),      64'd0);
    trig = 1'b0;
    arm  = 1'b1;
    run_ramp(1, 1'b0);
    arm  = 1'b0;
    check("armed_busy", 64'(busy1), 64'd1);
    run_ramp(3, 1'b0);
    trig = 1'b1;
    run_ramp(1, 1'b0);
    trig = 1'b0;
    run_ramp(24, 1'b0);
    check("trig_writes", 64'(wr1.size()), 64'(1 + FW));
    check("trig_busy",   64'(busy1),      64'd0);
    if (wr1.size() >= 1) check("trig_hdr", 64'(wr1[0]), 64'h005A010000);

    // afull over two data-word slots: both dropped, ovf shows in the next header only.
    cfg_mode = 1'b0;
    do_reset();
    wr1.delete();
    drive(1'b0, '0, 1'b0);
    cyc();
    run_ramp(2, 1'b0);
    run_ramp(6, 1'b1);
    run_ramp(26, 1'b0);
    check("afull_drop_cnt", 64'(drop1),       64'd2);
    check("afull_writes",   64'(wr1.size()),  64'd9);
    if (wr1.size() >= 9) begin
      check("afull_hdr0", 64'(wr1[0]), 64'h005A010000);
      check("afull_hdr1", 64'(wr1[3]), 64'h00DA010001);
      check("afull_hdr2", 64'(wr1[8]), 64'h005A010002);
    end

    // Reset with two lanes filled: partial word discarded, sequence and drops cleared.
    wr1.delete();
    reset = 1'b1;
    run_ramp(2, 1'b0);
    reset  = 1'b0;
    ramp_v = 0;
    drive(1'b0, '0, 1'b0);
    cyc();
    check("rst_no_writes", 64'(wr1.size()), 64'd0);
    check("rst_drop_cnt",  64'(drop1),      64'd0);
    run_ramp(2, 1'b0);
    check("rst_restart_writes", 64'(wr1.size()), 64'd1);
    if (wr1.size() >= 1) check("rst_restart_hdr", 64'(wr1[0]), 64'h005A010000);

    // Randomized traffic against the model.
    for (int r = 0; r < 12; r++) begin
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_dec  = DEC_W'($urandom_range(0, 3));
      do_reset();
      for (int c = 0; c < 160; c++) begin
        arm  = ($urandom_range(0, 7) == 0);
        trig = ($urandom_range(0, 3) == 0);
        drive($urandom_range(0, 3) != 0, SW'($urandom), $urandom_range(0, 15) == 0);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
